// File: rtl/nes_pad_reader.sv
// -----------------------------------------------------------------------------
// nes_pad_reader
//
// Polls an NES controller over its latch / pulse / data serial protocol and
// presents the eight buttons to the Tetris game logic as a stable active-high
// vector, together with one-cycle "newly pressed" pulses.
//
// Build option:
//   NES_DEBOUNCE_EN  when defined, a frame's byte is only accepted once two
//                    consecutive frames read the same raw value. This adds one
//                    frame of latency to every change. When undefined, every
//                    completed frame updates the outputs directly.
//
// Parameters:
//   TICK_DIV  clk cycles per protocol tick (min 4)
//   POLL_DIV  clk cycles between latch starts (must exceed 17*TICK_DIV+4)
//
// Ports:
//   clk         system clock
//   hard_reset  asynchronous active-low reset
//   nes_in      serial data from the controller, low = pressed, async to clk
//   nes_latch   latch strobe to the controller, active-high
//   nes_pulse   shift clock to the controller, active-high
//   buttons     [7]A [6]B [5]Select [4]Start [3]Up [2]Down [1]Left [0]Right,
//               1 = pressed
//   btn_valid   one-cycle pulse when a frame completes
//   btn_press   rising-edge pulses per button, non-zero only with btn_valid
//   state_dbg   current FSM state encoding, for observation only
//
// Handshake: btn_valid is a one-cycle strobe with no ready; btn_press is
// qualified by btn_valid and buttons is stable between strobes.
//
// Frame shape (ticks): LATCH 2, GAP 1, then 7 x (HIGH 1, LOW 1) = 17 ticks,
// followed by a single DONE cycle. Bit 0 (A) is sampled at the end of GAP,
// bits 1..7 at the end of each LOW.
// -----------------------------------------------------------------------------
module nes_pad_reader #(
  parameter int TICK_DIV = 150,
  parameter int POLL_DIV = 416667
) (
  input  logic       clk,
  input  logic       hard_reset,
  input  logic       nes_in,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons,
  output logic       btn_valid,
  output logic [7:0] btn_press,
  output logic [2:0] state_dbg
);

  // Counter widths: $clog2(N) bits are enough to hold 0..N-1.
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);

  // FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_LOW   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] poll_cnt;
  logic [2:0]    bit_cnt;     // number of bits already captured this frame
  logic          latch_half;  // 0 = first latch tick, 1 = second latch tick
  logic [7:0]    raw;         // active-low bits, A shifted in first
  logic          sync_1;
  logic          sync_2;

  logic          tick_end;
  logic          poll_end;
  logic [7:0]    new_btn;

  assign tick_end = (tick_cnt == TICK_LAST);
  assign poll_end = (poll_cnt == POLL_LAST);
  assign new_btn  = ~raw;

  // Strobes are decoded straight from the state register so that an
  // asynchronous reset drops them in the same instant.
  assign nes_latch = (state == ST_LATCH);
  assign nes_pulse = (state == ST_HIGH);
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Resets to 1 (the idle / released level of the line).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= nes_in;
      sync_2 <= sync_1;
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running poll counter. It keeps running during a frame; a wrap that
  // lands outside IDLE is simply not acted upon.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      poll_cnt <= '0;
    end else if (poll_end) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol FSM, tick counter and deserialiser.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= 3'd0;
      latch_half <= 1'b0;
      raw        <= 8'hFF;
    end else begin
      case (state)
        ST_IDLE: begin
          tick_cnt   <= '0;
          bit_cnt    <= 3'd0;
          latch_half <= 1'b0;
          if (poll_end) begin
            state <= ST_LATCH;
          end
        end

        ST_LATCH: begin
          if (tick_end) begin
            tick_cnt <= '0;
            if (latch_half) begin
              latch_half <= 1'b0;
              state      <= ST_GAP;
            end else begin
              latch_half <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        ST_GAP: begin
          if (tick_end) begin
            // The controller presents A right after the latch falls.
            tick_cnt <= '0;
            raw      <= {raw[6:0], sync_2};
            bit_cnt  <= 3'd1;
            state    <= ST_HIGH;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        ST_HIGH: begin
          if (tick_end) begin
            tick_cnt <= '0;
            state    <= ST_LOW;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        ST_LOW: begin
          if (tick_end) begin
            tick_cnt <= '0;
            raw      <= {raw[6:0], sync_2};
            if (bit_cnt == 3'd7) begin
              // That was bit 7 (Right): the byte is complete.
              bit_cnt <= 3'd0;
              state   <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              state   <= ST_HIGH;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          tick_cnt <= '0;
          state    <= ST_IDLE;
        end

        default: begin
          tick_cnt   <= '0;
          bit_cnt    <= 3'd0;
          latch_half <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers, updated on the DONE cycle so that btn_valid and
  // btn_press are high for exactly the cycle after DONE.
  // ---------------------------------------------------------------------------
`ifdef NES_DEBOUNCE_EN
  logic [7:0] prev_raw;  // raw byte of the previous completed frame

  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      buttons   <= 8'h00;
      btn_press <= 8'h00;
      btn_valid <= 1'b0;
      prev_raw  <= 8'hFF;
    end else begin
      btn_valid <= 1'b0;
      btn_press <= 8'h00;
      if (state == ST_DONE) begin
        btn_valid <= 1'b1;
        prev_raw  <= raw;
        // Only a byte seen twice in a row is trusted.
        if (raw == prev_raw) begin
          btn_press <= new_btn & ~buttons;
          buttons   <= new_btn;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      buttons   <= 8'h00;
      btn_press <= 8'h00;
      btn_valid <= 1'b0;
    end else begin
      btn_valid <= 1'b0;
      btn_press <= 8'h00;
      if (state == ST_DONE) begin
        btn_valid <= 1'b1;
        // Releases produce no pulse: only 0 -> 1 transitions are reported.
        btn_press <= new_btn & ~buttons;
        buttons   <= new_btn;
      end
    end
  end
`endif

endmodule
